// File: rtl/neuron_accum.sv
// neuron_accum: streamed pixel*weight multiply-accumulate plus bias, delivering a Q8.14 pre-activation.
// Optional macro NEURON_SAT_EN clamps the result to the Q8.14 range; otherwise it wraps.
module neuron_accum #(
    parameter int N_INPUTS = 784,
    parameter int ACC_W    = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [21:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  pixel,
    input  logic [7:0]  weight,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [21:0] sum_out,
    output logic        busy
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [16:0]       prod_q, prod_d;
    logic                     prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [21:0]              bias_q, bias_d;
    logic [21:0]              sum_out_q, sum_out_d;
    logic                     in_ready_q, in_ready_d;
    logic                     sum_valid_q, sum_valid_d;
    logic                     busy_q, busy_d;
    logic                     beat;
    logic signed [16:0]       pix_ext, wt_ext;
    logic [21:0]              reduced;

    assign beat    = in_valid && in_ready_q;
    assign pix_ext = $signed({9'b0, pixel});
    assign wt_ext  = 17'($signed(weight));

`ifdef NEURON_SAT_EN
    logic signed [ACC_W-1:0] sum;
    logic                    ovf;
    assign sum     = acc_q + {{(ACC_W-22){bias_q[21]}}, bias_q};
    assign ovf     = !((&sum[ACC_W-1:21]) || !(|sum[ACC_W-1:21]));
    assign reduced = ovf ? (sum[ACC_W-1] ? 22'h200000 : 22'h1FFFFF) : sum[21:0];
`else
    assign reduced = acc_q[21:0] + bias_q;
`endif

    // Next-state: sequencer, operand product stage, accumulator and result register
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bias_d    = bias_q;
        prod_d    = prod_q;
        prod_v_d  = beat;
        acc_d     = prod_v_q ? acc_q + ACC_W'(prod_q) : acc_q;
        sum_out_d = sum_out_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                bias_d  = bias;
                cnt_d   = '0;
                acc_d   = '0;
            end
            ACCUM: if (beat) begin
                prod_d = pix_ext * wt_ext;
                cnt_d  = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(N_INPUTS - 1)) ? DRAIN : ACCUM;
            end
            DRAIN: state_d = BIAS;
            BIAS: begin
                sum_out_d = reduced;
                state_d   = OUT;
            end
            OUT: state_d = sum_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        sum_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bias_q      <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            sum_out_q   <= '0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            sum_out_q   <= sum_out_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sum_valid = sum_valid_q;
    assign sum_out   = sum_out_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_neuron_accum.sv
// tb_neuron_accum: vector table, random transactions against an arithmetic model, and corner sequences.
module tb_neuron_accum;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, sum_ready;
    logic [21:0] bias;
    logic [7:0]  pixel, weight;
    logic        in_ready, sum_valid, busy;
    logic [21:0] sum_out;

    logic        b_start, b_in_valid, b_sum_ready;
    logic [21:0] b_bias;
    logic [7:0]  b_pixel, b_weight;
    logic        b_in_ready, b_sum_valid, b_busy;
    logic [21:0] b_sum_out;

    neuron_accum #(.N_INPUTS(4), .ACC_W(26)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weight(weight),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_out(sum_out), .busy(busy)
    );

    neuron_accum #(.N_INPUTS(128), .ACC_W(26)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .bias(b_bias),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .pixel(b_pixel), .weight(b_weight),
        .sum_valid(b_sum_valid), .sum_ready(b_sum_ready), .sum_out(b_sum_out), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer sum of bias and products, then clamp or wrap to 22 bits
    function automatic logic [21:0] ref_sum(input logic [21:0] b, input logic [3:0][7:0] px,
                                            input logic [3:0][7:0] wt);
        longint s;
        s = longint'($signed(b));
        for (int i = 0; i < 4; i++) s += longint'(px[i]) * longint'($signed(wt[i]));
`ifdef NEURON_SAT_EN
        if (s > 64'sd2097151) return 22'h1FFFFF;
        if (s < -64'sd2097152) return 22'h200000;
`endif
        return s[21:0];
    endfunction

    task automatic run(input logic [21:0] b, input logic [3:0][7:0] px, input logic [3:0][7:0] wt,
                       input bit gaps, input int hold, input bit pulse, output logic [21:0] res);
        int  k, guard, lat;
        bit  acc, stable;
        chk("idle_ready", 32'(in_ready), 32'd0);
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        start = 1'b0;
        bias  = 22'h2AAAAA;
        chk("ready_rise", 32'(in_ready), 32'd1);
        chk("busy_high", 32'(busy), 32'd1);
        k = 0;
        guard = 0;
        while (k < 4 && guard < 200) begin
            in_valid = !gaps || ($urandom_range(0, 2) != 0);
            pixel    = px[k];
            weight   = wt[k];
            start    = pulse && (k == 2);
            if (start) bias = 22'h155555;
            acc = in_valid && in_ready;
            @(negedge clk);
            guard++;
            if (acc) k++;
        end
        start = 1'b0;
        if (guard >= 200) chk("beat_timeout", 32'(k), 32'd4);
        in_valid = 1'b1;
        pixel    = 8'hFF;
        weight   = 8'h7F;
        lat = 1;
        while (!sum_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency_edges", 32'(lat), 32'd3);
        res = sum_out;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (sum_out !== res || !sum_valid || in_ready) stable = 1'b0;
        end
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hold_stable", 32'(stable), 32'd1);
        chk("valid_drop", 32'(sum_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
    endtask

    task automatic run_big(input logic [7:0] w, output logic [21:0] res);
        int k, guard;
        bit acc;
        b_start = 1'b1;
        b_bias  = 22'h0;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        guard = 0;
        while (k < 128 && guard < 400) begin
            b_in_valid = 1'b1;
            b_pixel    = 8'd255;
            b_weight   = w;
            acc = b_in_valid && b_in_ready;
            @(negedge clk);
            guard++;
            if (acc) k++;
        end
        b_in_valid = 1'b0;
        chk("big_no_gaps", 32'(guard), 32'd128);
        guard = 0;
        while (!b_sum_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        res = b_sum_out;
        b_sum_ready = 1'b1;
        @(negedge clk);
        b_sum_ready = 1'b0;
    endtask

    typedef struct {
        logic [21:0]      b;
        logic [3:0][7:0]  px;
        logic [3:0][7:0]  wt;
        logic [21:0]      exp;
    } vec_t;

`ifdef NEURON_SAT_EN
    localparam logic [21:0] E_HI = 22'h1FFFFF, E_LO = 22'h200000;
    localparam logic [21:0] E_BIG_HI = 22'h1FFFFF, E_BIG_LO = 22'h200000;
`else
    localparam logic [21:0] E_HI = 22'h21FA03, E_LO = 22'h1E0200;
    localparam logic [21:0] E_BIG_HI = 22'h3F4080, E_BIG_LO = 22'h004000;
`endif

    initial begin
        vec_t            tbl[4];
        logic [21:0]     res, rb;
        logic [3:0][7:0] rp, rw;
        int              hold;
        bit              pulse;
        tbl[0] = '{22'h000000, {4{8'd255}}, {4{8'd64}},  22'h00FF00};
        tbl[1] = '{22'h3FC000, {4{8'd128}}, {4{8'd64}},  22'h004000};
        tbl[2] = '{22'h1FFFFF, {4{8'd255}}, {4{8'd127}}, E_HI};
        tbl[3] = '{22'h200000, {4{8'd255}}, {4{8'h80}},  E_LO};
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sum_ready = 1'b0;
        bias = '0; pixel = '0; weight = '0;
        b_start = 1'b0; b_in_valid = 1'b0; b_sum_ready = 1'b0;
        b_bias = '0; b_pixel = '0; b_weight = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum_out", 32'(sum_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run(tbl[i].b, tbl[i].px, tbl[i].wt, 1'b0, 0, 1'b0, res);
            chk($sformatf("table_%0d", i), 32'(res), 32'(tbl[i].exp));
        end

        for (int t = 0; t < 16; t++) begin
            rb = 22'($urandom);
            for (int j = 0; j < 4; j++) begin
                rp[j] = 8'($urandom);
                rw[j] = 8'($urandom);
            end
            hold  = (t == 0) ? 10 : int'($urandom_range(0, 4));
            pulse = 1'($urandom);
            run(rb, rp, rw, 1'b1, hold, pulse, res);
            chk($sformatf("random_%0d", t), 32'(res), 32'(ref_sum(rb, rp, rw)));
        end

        run(22'h004000, {4{8'd100}}, {4{8'd50}}, 1'b0, 2, 1'b1, res);
        chk("start_ignored", 32'(res), 32'h008E20);

        start = 1'b1;
        bias  = 22'h0ABCDE;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        pixel    = 8'd200;
        weight   = 8'd100;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("mid_rst_sum_out", 32'(sum_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        run(22'h0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b0, 0, 1'b0, res);
        chk("after_rst", 32'(res), 32'h00012C);

        run_big(8'd127, res);
        chk("big_pos", 32'(res), 32'(E_BIG_HI));
        run_big(8'h80, res);
        chk("big_neg", 32'(res), 32'(E_BIG_LO));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
